// File: rtl/pixel_pkg.sv
// Shared screen geometry, pixel record and address helper for the pixel sink.
package pixel_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int COLOR_W  = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_t;

  // 320 = 256 + 64, so the common screen width avoids a multiplier.
  function automatic logic [31:0] xy_to_addr(input logic [X_W-1:0] x,
                                             input logic [Y_W-1:0] y,
                                             input logic [31:0]    scr_w);
    logic [31:0] w_xe;
    logic [31:0] w_ye;
    w_xe = 32'(x);
    w_ye = 32'(y);
    if (scr_w == 32'd320) return (w_ye << 8) + (w_ye << 6) + w_xe;
    else                  return (w_ye * scr_w) + w_xe;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO; the caller guarantees no push when full without a pop
// and no pop when empty.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == L_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pixel_plot_sink.sv
// Buffers drawer pixels, clips off-screen ones and streams one framebuffer
// write per pixel through a stallable write port.
module pixel_plot_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H   = pixel_pkg::SCREEN_H,
  parameter int COLOR_W    = pixel_pkg::COLOR_W,
  parameter int ADDR_W     = 17
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               plot,
  input  logic [8:0]         xCoord,
  input  logic [7:0]         yCoord,
  input  logic [COLOR_W-1:0] color,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               fifo_full,
  output logic               idle,
  output logic [7:0]         overflow_count,
  output logic [7:0]         clip_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] L_FULL = CW'(FIFO_DEPTH);
  localparam logic [31:0]   L_SW   = 32'(SCREEN_W);
  localparam logic [31:0]   L_SH   = 32'(SCREEN_H);

  pixel_pkg::pixel_t    w_in_pix;
  pixel_pkg::pixel_t    w_head;
  pixel_pkg::wr_state_t r_state;

  logic              w_full, w_empty, w_in_range;
  logic              w_push, w_pop, w_clip, w_ovf, w_we_nxt;
  logic [CW-1:0]     w_count, w_count_nxt;
  logic [ADDR_W-1:0] w_head_addr;

  logic               r_fb_we;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic [COLOR_W-1:0] r_fb_data;
  logic               r_fifo_full, r_idle;
  logic [7:0]         r_ovf_cnt, r_clip_cnt;

  assign w_in_pix   = '{x: xCoord, y: yCoord, color: color};
  assign w_in_range = (32'(xCoord) < L_SW) && (32'(yCoord) < L_SH);

  // A slot frees up either from IDLE or when the held write is accepted.
  assign w_pop  = !w_empty && ((r_state == pixel_pkg::S_IDLE) || fb_ready);
  assign w_clip = plot && !w_in_range;
  assign w_ovf  = plot && w_in_range && w_full && !w_pop;
  assign w_push = plot && w_in_range && (!w_full || w_pop);

  assign w_we_nxt = w_pop ? 1'b1
                  : ((r_state == pixel_pkg::S_WRITE) && fb_ready) ? 1'b0
                  : r_fb_we;

  assign w_head_addr = ADDR_W'(pixel_pkg::xy_to_addr(w_head.x, w_head.y, L_SW));

  always_comb begin
    w_count_nxt = w_count;
    if (w_push && !w_pop)      w_count_nxt = w_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = w_count - CW'(1);
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_pkg::pixel_t))
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in_pix),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= pixel_pkg::S_IDLE;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= '0;
      r_fifo_full <= 1'b0;
      r_idle      <= 1'b1;
      r_ovf_cnt   <= '0;
      r_clip_cnt  <= '0;
    end else begin
      case (r_state)
        pixel_pkg::S_IDLE: begin
          if (w_pop) r_state <= pixel_pkg::S_WRITE;
        end
        pixel_pkg::S_WRITE: begin
          if (fb_ready && !w_pop) r_state <= pixel_pkg::S_IDLE;
        end
        default: r_state <= pixel_pkg::S_IDLE;
      endcase
      if (w_pop) begin
        r_fb_addr <= w_head_addr;
        r_fb_data <= w_head.color;
      end
      r_fb_we     <= w_we_nxt;
      r_fifo_full <= (w_count_nxt == L_FULL);
      r_idle      <= (w_count_nxt == '0) && !w_we_nxt;
      if (w_ovf && (r_ovf_cnt != 8'hFF))   r_ovf_cnt  <= r_ovf_cnt + 8'd1;
      if (w_clip && (r_clip_cnt != 8'hFF)) r_clip_cnt <= r_clip_cnt + 8'd1;
    end
  end

  assign fb_we          = r_fb_we;
  assign fb_addr        = r_fb_addr;
  assign fb_data        = r_fb_data;
  assign fifo_full      = r_fifo_full;
  assign idle           = r_idle;
  assign overflow_count = r_ovf_cnt;
  assign clip_count     = r_clip_cnt;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Bench for pixel_plot_sink: directed scenarios plus random traffic against a
// transaction-level model (pixel queue + one in-flight write slot).
module tb_pixel_plot_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        plot = 1'b0;
  logic [8:0]  xCoord = '0;
  logic [7:0]  yCoord = '0;
  logic [2:0]  color = '0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_ready = 1'b0;
  logic        fifo_full;
  logic        idle;
  logic [7:0]  overflow_count;
  logic [7:0]  clip_count;

  int total = 0;
  int bad   = 0;

  // Reference model: pixels waiting, plus the write currently presented.
  int q_addr[$];
  int q_data[$];
  bit m_busy;
  int m_addr, m_data;
  int m_clip, m_ovf;

  pixel_plot_sink dut (
    .clock          (clock),
    .reset          (reset),
    .plot           (plot),
    .xCoord         (xCoord),
    .yCoord         (yCoord),
    .color          (color),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .fb_ready       (fb_ready),
    .fifo_full      (fifo_full),
    .idle           (idle),
    .overflow_count (overflow_count),
    .clip_count     (clip_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_addr.delete();
    q_data.delete();
    m_busy = 1'b0;
    m_addr = 0;
    m_data = 0;
    m_clip = 0;
    m_ovf  = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".we"}, 32'(fb_we), 32'(m_busy));
    if (m_busy) begin
      check({tag, ".addr"}, 32'(fb_addr), m_addr);
      check({tag, ".data"}, 32'(fb_data), m_data);
    end
    check({tag, ".full"}, 32'(fifo_full), 32'(q_addr.size() == 8));
    check({tag, ".idle"}, 32'(idle), 32'(q_addr.size() == 0 && !m_busy));
    check({tag, ".ovf"},  32'(overflow_count), m_ovf);
    check({tag, ".clip"}, 32'(clip_count), m_clip);
  endtask

  // One clock edge with the given inputs; model advanced, outputs compared.
  task automatic step(input string tag, input bit p, input int x, input int y,
                      input int c, input bit rdy);
    bit pop;
    plot     = p;
    xCoord   = 9'(x);
    yCoord   = 8'(y);
    color    = 3'(c);
    fb_ready = rdy;
    pop = (q_addr.size() > 0) && (!m_busy || rdy);
    if (m_busy && rdy) m_busy = 1'b0;
    if (pop) begin
      m_addr = q_addr.pop_front();
      m_data = q_data.pop_front();
      m_busy = 1'b1;
    end
    if (p) begin
      if (x >= 320 || y >= 240) begin
        if (m_clip < 255) m_clip++;
      end else if (q_addr.size() == 8) begin
        if (m_ovf < 255) m_ovf++;
      end else begin
        q_addr.push_back(y * 320 + x);
        q_data.push_back(c);
      end
    end
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag, input bit rdy);
    reset    = 1'b1;
    plot     = 1'b0;
    fb_ready = rdy;
    @(posedge clock);
    #1;
    model_clear();
    check({tag, ".we"},   32'(fb_we), 0);
    check({tag, ".addr"}, 32'(fb_addr), 0);
    check({tag, ".data"}, 32'(fb_data), 0);
    check({tag, ".full"}, 32'(fifo_full), 0);
    check({tag, ".idle"}, 32'(idle), 1);
    check({tag, ".ovf"},  32'(overflow_count), 0);
    check({tag, ".clip"}, 32'(clip_count), 0);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    do_reset("reset", 1'b0);

    // Single pixel through an always-ready framebuffer.
    step("single0", 1'b1, 5, 2, 4, 1'b1);
    step("single1", 1'b0, 0, 0, 0, 1'b1);
    check("single.we", 32'(fb_we), 1);
    check("single.addr", 32'(fb_addr), 645);
    check("single.data", 32'(fb_data), 4);
    step("single2", 1'b0, 0, 0, 0, 1'b1);
    check("single.idle", 32'(idle), 1);

    // Burst of 16 into a stalled framebuffer, then release.
    do_reset("rst_burst", 1'b0);
    for (int i = 0; i < 16; i++) step("burst", 1'b1, i, 16, i % 8, 1'b0);
    for (int i = 0; i < 4; i++)  step("stall", 1'b0, 0, 0, 0, 1'b0);
    check("burst.ovf", 32'(overflow_count), 7);
    check("burst.full", 32'(fifo_full), 1);
    check("burst.head", 32'(fb_addr), 5120);
    for (int i = 0; i < 9; i++) begin
      step("drain", 1'b0, 0, 0, 0, 1'b1);
      if (i < 8) check("drain.addr_seq", 32'(fb_addr), 32'(5121 + i));
    end
    step("drain_end", 1'b0, 0, 0, 0, 1'b1);
    check("drain.idle", 32'(idle), 1);

    // Clipping on each axis and the last on-screen pixel.
    do_reset("rst_clip", 1'b1);
    step("clip_x", 1'b1, 320, 0, 1, 1'b1);
    step("clip_y", 1'b1, 0, 240, 2, 1'b1);
    step("clip_in", 1'b1, 319, 239, 5, 1'b1);
    step("clip_w", 1'b0, 0, 0, 0, 1'b1);
    check("clip.count", 32'(clip_count), 2);
    check("clip.addr", 32'(fb_addr), 76799);
    for (int i = 0; i < 2; i++) step("clip_tail", 1'b0, 0, 0, 0, 1'b1);

    // Push and pop on the same edge while full.
    do_reset("rst_pp", 1'b0);
    for (int i = 0; i < 9; i++) step("pp_fill", 1'b1, 10 + i, 3, i % 8, 1'b0);
    check("pp.full_before", 32'(fifo_full), 1);
    step("pp_both", 1'b1, 100, 50, 6, 1'b1);
    check("pp.full_after", 32'(fifo_full), 1);
    check("pp.ovf", 32'(overflow_count), 0);
    for (int i = 0; i < 12; i++) step("pp_drain", 1'b0, 0, 0, 0, 1'b1);

    // Reset while a write is held and five pixels wait.
    do_reset("rst_mid0", 1'b0);
    for (int i = 0; i < 6; i++) step("mid_fill", 1'b1, 40 + i, 7, i, 1'b0);
    check("mid.we", 32'(fb_we), 1);
    do_reset("rst_mid", 1'b1);
    for (int i = 0; i < 8; i++) step("mid_after", 1'b0, 0, 0, 0, 1'b1);

    // Clip counter saturation.
    do_reset("rst_sat", 1'b1);
    for (int i = 0; i < 300; i++)
      step("sat", 1'b1, int'($urandom_range(320, 511)), int'($urandom_range(0, 255)), 0, 1'b1);
    check("sat.clip", 32'(clip_count), 255);
    step("sat_hold", 1'b1, 0, 250, 0, 1'b1);
    check("sat.hold", 32'(clip_count), 255);

    // Random traffic with random stalls.
    do_reset("rst_rand", 1'b0);
    for (int i = 0; i < 500; i++)
      step("rand", $urandom_range(0, 9) < 7, int'($urandom_range(0, 340)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) step("rand_drain", 1'b0, 0, 0, 0, 1'b1);
    check("rand.idle", 32'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
